// File: rtl/gpio_irq_pkg.sv
// gpio_irq_pkg: shared constants for the Wishbone GPIO controller.
//   MAX_WIDTH   - widest supported pin count (one bus word)
//   ADDR_*      - register offsets decoded from wb_adr_i[7:0]
//   lane_mask() - expands wb_sel_i byte enables into a 32-bit bit mask
package gpio_irq_pkg;

  localparam int MAX_WIDTH = 32;

  localparam logic [7:0] ADDR_DATA      = 8'h00;
  localparam logic [7:0] ADDR_ENA       = 8'h04;
  localparam logic [7:0] ADDR_PU        = 8'h08;
  localparam logic [7:0] ADDR_PD        = 8'h0C;
  localparam logic [7:0] ADDR_OUT_SET   = 8'h10;
  localparam logic [7:0] ADDR_OUT_CLR   = 8'h14;
  localparam logic [7:0] ADDR_OUT_TGL   = 8'h18;
  localparam logic [7:0] ADDR_OUT       = 8'h1C;
  localparam logic [7:0] ADDR_IRQ_EN    = 8'h20;
  localparam logic [7:0] ADDR_IRQ_RISE  = 8'h24;
  localparam logic [7:0] ADDR_IRQ_FALL  = 8'h28;
  localparam logic [7:0] ADDR_IRQ_STAT  = 8'h2C;

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

endpackage

// File: rtl/gpio_irq_wb_sync.sv
// gpio_sync_edge: input synchroniser plus edge detection for the GPIO pads.
//   clk   - system clock
//   rst   - synchronous active-high reset
//   din   - asynchronous pad inputs
//   sync  - synchronised inputs (SYNC_STAGES flops deep)
//   rise  - one-cycle pulse per pin on a 0->1 of sync, once armed
//   fall  - one-cycle pulse per pin on a 1->0 of sync, once armed
module gpio_sync_edge
  import gpio_irq_pkg::*;
#(
  parameter int WIDTH       = MAX_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam logic [2:0] ARM_CYCLES = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] stage_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [2:0]       arm_cnt_q;
  logic             armed;

  // The synchroniser flushes zeros after reset, so a pin that is already high
  // looks like a rising edge once it reaches the end of the chain. The arming
  // counter suppresses edges until that flush has completed.
  assign armed = (arm_cnt_q == ARM_CYCLES);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
      prev_q    <= '0;
      arm_cnt_q <= '0;
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
      prev_q <= stage_q[SYNC_STAGES-1];
      if (!armed) arm_cnt_q <= arm_cnt_q + 3'd1;
    end
  end

  assign sync = stage_q[SYNC_STAGES-1];
  assign rise = armed ? (sync & ~prev_q) : '0;
  assign fall = armed ? (~sync & prev_q) : '0;

endmodule

// File: rtl/gpio_irq_wb.sv
// gpio_irq_wb: Wishbone GPIO controller with per-pin edge interrupts.
//   wb_*_i / wb_*_o - Wishbone slave (single clock wb_clk_i, sync reset wb_rst_i)
//   gpio_in         - asynchronous pad inputs
//   gpio_out        - pad output data
//   gpio_oeb        - active-low output enables (inverse of ENA)
//   gpio_pu/gpio_pd - pull-up / pull-down enables
//   irq_o           - level interrupt, OR of enabled captured edges
module gpio_irq_wb
  import gpio_irq_pkg::*;
#(
  parameter int WIDTH       = MAX_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [31:0]      wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  input  logic [3:0]       wb_sel_i,
  input  logic             wb_we_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oeb,
  output logic [WIDTH-1:0] gpio_pu,
  output logic [WIDTH-1:0] gpio_pd,
  output logic             irq_o
);

  logic [WIDTH-1:0] ena_q, irq_en_q, rise_sel_q, fall_sel_q, stat_q;
  logic [WIDTH-1:0] sync, rise, fall;
  logic [WIDTH-1:0] byte_en, wr_bits, capture, stat_clr;
  logic [31:0]      lane_full, rdata;
  logic [7:0]       offset;
  logic             req, wr_en;
  logic             unused_bits;

  gpio_sync_edge #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .din  (gpio_in),
    .sync (sync),
    .rise (rise),
    .fall (fall)
  );

  // A request is only recognised while no ack is outstanding, which makes a
  // held strobe complete every second cycle.
  assign req       = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr_en     = req & wb_we_i;
  assign offset    = wb_adr_i[7:0];
  assign lane_full = lane_mask(wb_sel_i);
  assign byte_en   = lane_full[WIDTH-1:0];
  assign wr_bits   = wb_dat_i[WIDTH-1:0] & byte_en;

  assign capture  = (rise & rise_sel_q) | (fall & fall_sel_q);
  assign stat_clr = (wr_en && offset == ADDR_IRQ_STAT) ? wr_bits : '0;

  assign gpio_oeb = ~ena_q;
  assign irq_o    = |(stat_q & irq_en_q);

  assign unused_bits = ^{wb_adr_i[31:8], lane_full, wb_dat_i};

  // Read mux; write-only and unmapped offsets return zero, and upper bus
  // bits above WIDTH are always zero.
  always_comb begin
    rdata = '0;
    case (offset)
      ADDR_DATA:     rdata[WIDTH-1:0] = sync;
      ADDR_ENA:      rdata[WIDTH-1:0] = ena_q;
      ADDR_PU:       rdata[WIDTH-1:0] = gpio_pu;
      ADDR_PD:       rdata[WIDTH-1:0] = gpio_pd;
      ADDR_OUT:      rdata[WIDTH-1:0] = gpio_out;
      ADDR_IRQ_EN:   rdata[WIDTH-1:0] = irq_en_q;
      ADDR_IRQ_RISE: rdata[WIDTH-1:0] = rise_sel_q;
      ADDR_IRQ_FALL: rdata[WIDTH-1:0] = fall_sel_q;
      ADDR_IRQ_STAT: rdata[WIDTH-1:0] = stat_q;
      default:       rdata = '0;
    endcase
  end

  // Bus handshake, register writes and edge capture. Every write is merged
  // under the byte-lane mask; STAT applies its clear before OR-ing in new
  // captures so a coincident edge is never lost.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_ack_o   <= 1'b0;
      wb_dat_o   <= '0;
      gpio_out   <= '0;
      ena_q      <= '0;
      gpio_pu    <= '0;
      gpio_pd    <= '0;
      irq_en_q   <= '0;
      rise_sel_q <= '0;
      fall_sel_q <= '0;
      stat_q     <= '0;
    end else begin
      wb_ack_o <= req;
      stat_q   <= (stat_q & ~stat_clr) | capture;
      if (req && !wb_we_i) wb_dat_o <= rdata;
      if (wr_en) begin
        case (offset)
          ADDR_DATA, ADDR_OUT: gpio_out   <= (gpio_out & ~byte_en) | wr_bits;
          ADDR_ENA:            ena_q      <= (ena_q & ~byte_en) | wr_bits;
          ADDR_PU:             gpio_pu    <= (gpio_pu & ~byte_en) | wr_bits;
          ADDR_PD:             gpio_pd    <= (gpio_pd & ~byte_en) | wr_bits;
          ADDR_OUT_SET:        gpio_out   <= gpio_out | wr_bits;
          ADDR_OUT_CLR:        gpio_out   <= gpio_out & ~wr_bits;
          ADDR_OUT_TGL:        gpio_out   <= gpio_out ^ wr_bits;
          ADDR_IRQ_EN:         irq_en_q   <= (irq_en_q & ~byte_en) | wr_bits;
          ADDR_IRQ_RISE:       rise_sel_q <= (rise_sel_q & ~byte_en) | wr_bits;
          ADDR_IRQ_FALL:       fall_sel_q <= (fall_sel_q & ~byte_en) | wr_bits;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gpio_irq_wb.sv
// tb_gpio_irq_wb: self-checking bench for gpio_irq_wb. A 32-pin instance
// covers the register map and interrupt paths; an 8-pin instance covers
// narrow-width readback, unmapped offsets and held-strobe throughput.
module tb_gpio_irq_wb;
  import gpio_irq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr, dat_i;
  logic [3:0]  sel;
  logic        we, cyc, stb, cyc8, stb8;
  logic [31:0] dat_o, dat_o8;
  logic        ack, ack8, irq, irq8;
  logic [31:0] gin, gout, goeb, gpu, gpd;
  logic [7:0]  gin8, gout8, goeb8, gpu8, gpd8;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rd, exp;

  always #5 clk = ~clk;

  gpio_irq_wb #(.WIDTH(32), .SYNC_STAGES(2)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_dat_o(dat_o), .wb_ack_o(ack), .gpio_in(gin), .gpio_out(gout),
    .gpio_oeb(goeb), .gpio_pu(gpu), .gpio_pd(gpd), .irq_o(irq)
  );

  gpio_irq_wb #(.WIDTH(8), .SYNC_STAGES(2)) dut8 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(dat_i),
    .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc8), .wb_stb_i(stb8),
    .wb_dat_o(dat_o8), .wb_ack_o(ack8), .gpio_in(gin8), .gpio_out(gout8),
    .gpio_oeb(goeb8), .gpio_pu(gpu8), .gpio_pd(gpd8), .irq_o(irq8)
  );

  // One bus transfer on either instance; returns at #1 after the ack edge.
  task automatic bus(input bit narrow, input bit wr, input logic [7:0] a,
                     input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rdata);
    bit done = 1'b0;
    rdata = '0;
    adr = {24'h0, a}; dat_i = d; sel = s; we = wr;
    if (narrow) begin cyc8 = 1'b1; stb8 = 1'b1; end
    else begin cyc = 1'b1; stb = 1'b1; end
    for (int i = 0; i < 8 && !done; i++) begin
      @(posedge clk); #1;
      if (narrow ? ack8 : ack) begin
        done = 1'b1;
        rdata = narrow ? dat_o8 : dat_o;
      end
    end
    cyc = 1'b0; stb = 1'b0; cyc8 = 1'b0; stb8 = 1'b0; we = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL bus_ack adr=%h got no ack, want ack within 8 cycles", a);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Pins already high through reset must not capture, even with RISE
  // enabled immediately after reset is released.
  task automatic test_arming();
    gin = '1; gin8 = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    bus(0, 1, ADDR_IRQ_RISE, 32'hFFFF_FFFF, 4'hF, rd);
    cycles(6);
    exp_q.push_back(32'h0);
    bus(0, 0, ADDR_IRQ_STAT, 32'h0, 4'hF, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("[TB] FAIL arm_stat got %h want %h", rd, exp); end
    exp_q.push_back(32'hFFFF_FFFF);
    bus(0, 0, ADDR_DATA, 32'h0, 4'hF, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("[TB] FAIL arm_data got %h want %h", rd, exp); end
  endtask

  task automatic test_reset();
    logic [7:0] addrs [13];
    addrs = '{ADDR_DATA, ADDR_ENA, ADDR_PU, ADDR_PD, ADDR_OUT_SET, ADDR_OUT_CLR,
              ADDR_OUT_TGL, ADDR_OUT, ADDR_IRQ_EN, ADDR_IRQ_RISE, ADDR_IRQ_FALL,
              ADDR_IRQ_STAT, 8'h30};
    gin = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ack !== 1'b0 || dat_o !== 32'h0 || irq !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_bus got ack=%b dat=%h irq=%b want 0 0 0", ack, dat_o, irq);
    end
    rst = 1'b0;
    cycles(4);
    checks++;
    if (goeb !== 32'hFFFF_FFFF || gout !== 32'h0 || gpu !== 32'h0 || gpd !== 32'h0 || goeb8 !== 8'hFF) begin
      errors++;
      $display("[TB] FAIL reset_pins got oeb=%h out=%h pu=%h pd=%h oeb8=%h want ffffffff 0 0 0 ff",
               goeb, gout, gpu, gpd, goeb8);
    end
    foreach (addrs[i]) begin
      exp_q.push_back(32'h0);
      bus(0, 0, addrs[i], 32'h0, 4'hF, rd);
      exp = exp_q.pop_front(); checks++;
      if (rd !== exp) begin errors++; $display("[TB] FAIL reset_read adr=%h got %h want %h", addrs[i], rd, exp); end
    end
  endtask

  task automatic test_out_ops();
    bus(0, 1, ADDR_OUT,     32'h0000_FFFF, 4'hF, rd);
    bus(0, 1, ADDR_OUT_SET, 32'h00F0_0000, 4'hF, rd);
    bus(0, 1, ADDR_OUT_CLR, 32'h0000_000F, 4'hF, rd);
    bus(0, 1, ADDR_OUT_TGL, 32'h0000_00F0, 4'hF, rd);
    exp_q.push_back(32'h00F0_FF00);
    bus(0, 0, ADDR_OUT, 32'h0, 4'hF, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("[TB] FAIL out_atomic got %h want %h", rd, exp); end
    bus(0, 1, ADDR_OUT, 32'hAABB_CCDD, 4'b0010, rd);
    exp_q.push_back(32'h00F0_CC00);
    bus(0, 0, ADDR_OUT, 32'h0, 4'hF, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("[TB] FAIL out_lane got %h want %h", rd, exp); end
    bus(0, 1, ADDR_DATA, 32'h1234_5678, 4'hF, rd);
    bus(0, 1, ADDR_OUT_SET, 32'hFFFF_FFFF, 4'b0001, rd);
    checks++;
    if (gout !== 32'h1234_56FF) begin errors++; $display("[TB] FAIL out_pins got %h want %h", gout, 32'h1234_56FF); end
    exp_q.push_back(32'h0);
    bus(0, 0, ADDR_OUT_SET, 32'h0, 4'hF, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("[TB] FAIL out_set_read got %h want %h", rd, exp); end
  endtask

  task automatic test_ena_pull();
    bus(0, 1, ADDR_ENA, 32'h0000_FF00, 4'hF, rd);
    bus(0, 1, ADDR_PU,  32'hA5A5_A5A5, 4'b0101, rd);
    bus(0, 1, ADDR_PD,  32'h5A5A_5A5A, 4'hF, rd);
    checks++;
    if (goeb !== 32'hFFFF_00FF || gpu !== 32'h00A5_00A5 || gpd !== 32'h5A5A_5A5A) begin
      errors++;
      $display("[TB] FAIL ena_pull_pins got oeb=%h pu=%h pd=%h want ffff00ff 00a500a5 5a5a5a5a", goeb, gpu, gpd);
    end
    exp_q.push_back(32'h00A5_00A5);
    bus(0, 0, ADDR_PU, 32'h0, 4'hF, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("[TB] FAIL pu_read got %h want %h", rd, exp); end
  endtask

  task automatic test_rise_irq();
    bus(0, 1, ADDR_IRQ_RISE, 32'h1, 4'hF, rd);
    bus(0, 1, ADDR_IRQ_EN,   32'h1, 4'hF, rd);
    gin[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("[TB] FAIL rise_early got irq=%b want 0", irq); end
    @(posedge clk); #1;
    checks++;
    if (irq !== 1'b1) begin errors++; $display("[TB] FAIL rise_latency got irq=%b want 1", irq); end
    exp_q.push_back(32'h1);
    bus(0, 0, ADDR_IRQ_STAT, 32'h0, 4'hF, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("[TB] FAIL rise_stat got %h want %h", rd, exp); end
    bus(0, 1, ADDR_IRQ_STAT, 32'h1, 4'hF, rd);
    cycles(1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("[TB] FAIL rise_w1c got irq=%b want 0", irq); end
  endtask

  task automatic test_fall_mask();
    bus(0, 1, ADDR_IRQ_EN, 32'h0, 4'hF, rd);
    gin[1] = 1'b1;
    cycles(6);
    bus(0, 1, ADDR_IRQ_FALL, 32'h2, 4'hF, rd);
    gin[1] = 1'b0;
    cycles(6);
    exp_q.push_back(32'h2);
    bus(0, 0, ADDR_IRQ_STAT, 32'h0, 4'hF, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("[TB] FAIL fall_stat got %h want %h", rd, exp); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("[TB] FAIL fall_masked got irq=%b want 0", irq); end
    bus(0, 1, ADDR_IRQ_EN, 32'h2, 4'hF, rd);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("[TB] FAIL fall_unmask got irq=%b want 1", irq); end
    bus(0, 1, ADDR_IRQ_STAT, 32'h2, 4'hF, rd);
  endtask

  task automatic test_w1c_collide();
    bus(0, 1, ADDR_IRQ_EN, 32'h0, 4'hF, rd);
    gin[0] = 1'b0;
    cycles(6);
    gin[0] = 1'b1;
    cycles(6);
    gin[0] = 1'b0;
    cycles(6);
    // New rising edge captures on the third edge; the W1C request lands on it too.
    gin[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus(0, 1, ADDR_IRQ_STAT, 32'h1, 4'hF, rd);
    exp_q.push_back(32'h1);
    bus(0, 0, ADDR_IRQ_STAT, 32'h0, 4'hF, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("[TB] FAIL collide_set_wins got %h want %h", rd, exp); end
    bus(0, 1, ADDR_IRQ_STAT, 32'h1, 4'hF, rd);
    exp_q.push_back(32'h0);
    bus(0, 0, ADDR_IRQ_STAT, 32'h0, 4'hF, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("[TB] FAIL collide_clear got %h want %h", rd, exp); end
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    bus(1, 1, ADDR_OUT, 32'hFFFF_FFFF, 4'hF, rd);
    exp_q.push_back(32'h0000_00FF);
    bus(1, 0, ADDR_OUT, 32'h0, 4'hF, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("[TB] FAIL w8_out got %h want %h", rd, exp); end
    checks++;
    if (gout8 !== 8'hFF) begin errors++; $display("[TB] FAIL w8_pins got %h want ff", gout8); end
    bus(1, 1, 8'h40, 32'h0, 4'hF, rd);
    exp_q.push_back(32'h0);
    bus(1, 0, 8'h40, 32'h0, 4'hF, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("[TB] FAIL w8_unmapped got %h want %h", rd, exp); end
    exp_q.push_back(32'h0000_00FF);
    bus(1, 0, ADDR_OUT, 32'h0, 4'hF, rd);
    exp = exp_q.pop_front(); checks++;
    if (rd !== exp) begin errors++; $display("[TB] FAIL w8_unmapped_wr got %h want %h", rd, exp); end
    adr = {24'h0, ADDR_OUT}; we = 1'b0; sel = 4'hF;
    cyc8 = 1'b1; stb8 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ack8) acks++;
    end
    cyc8 = 1'b0; stb8 = 1'b0;
    checks++;
    if (acks !== 3) begin errors++; $display("[TB] FAIL held_strobe got %0d acks want 3", acks); end
  endtask

  initial begin
    rst = 1'b1; adr = '0; dat_i = '0; sel = '0; we = 1'b0;
    cyc = 1'b0; stb = 1'b0; cyc8 = 1'b0; stb8 = 1'b0;
    gin = '0; gin8 = '0;
    test_arming();
    test_reset();
    test_out_ops();
    test_ena_pull();
    test_rise_irq();
    test_fall_mask();
    test_w1c_collide();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_irq_wb.md
# gpio_irq_wb

Parametrised Wishbone GPIO controller with per-pin interrupts. It is the successor to the 32-bit fixed GPIO peripheral and sits on the management-SoC Wishbone bus beside the other slave peripherals. It adds:

- configurable pin count;
- byte-lane write masking;
- atomic set/clear/toggle of outputs;
- a two-flop input synchroniser;
- per-pin rising/falling edge capture with a level interrupt output.

## Interface
Parameters:
- WIDTH, 32: number of GPIO pins, 1..32; unused upper data bits read 0.
- SYNC_STAGES, 2: input synchroniser depth, 2..3.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset; synchronous, active-high.
- wb_adr_i  in  32  byte address; only [7:0] decoded.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte-lane enables; a write updates only the selected bytes.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_dat_o  out  32  read data, registered.
- wb_ack_o  out  1  acknowledge, one-cycle pulse.
- gpio_in  in  WIDTH  pad inputs, asynchronous.
- gpio_out  out  WIDTH  pad output data.
- gpio_oeb  out  WIDTH  output enable, active-low.
- gpio_pu  out  WIDTH  pull-up enables.
- gpio_pd  out  WIDTH  pull-down enables.
- irq_o  out  1  level interrupt = |(IRQ_STAT & IRQ_EN).

## Operation
Register map (addr[7:0]; W1S = write-1-to-set, W1C = write-1-to-clear, W1T = write-1-to-toggle):
- 0x00 DATA: R returns the synchronised input; W sets OUT.
- 0x04 ENA: R/W, positive-sense output enable; gpio_oeb = ~ENA.
- 0x08 PU and 0x0C PD: R/W, driven directly to gpio_pu / gpio_pd.
- 0x10 OUT_SET (W1S), 0x14 OUT_CLR (W1C), 0x18 OUT_TGL (W1T): write-only, read 0.
- 0x1C OUT: R/W readback of the output register.
- 0x20 IRQ_EN: R/W.
- 0x24 IRQ_RISE and 0x28 IRQ_FALL: R/W edge selects; both set means any edge.
- 0x2C IRQ_STAT: R; W1C.
- Any other offset: acked, reads 0, writes ignored.

Byte-lane rule: for every write register, and for the W1S/W1C/W1T masks, only bytes with wb_sel_i set take effect.

Input path:
- gpio_in passes through SYNC_STAGES flops to give `sync`.
- `prev` is `sync` delayed by one cycle.
- rise = sync & ~prev; fall = ~sync & prev.

Edge capture:
- STAT[i] sets when (rise[i] & RISE[i]) | (fall[i] & FALL[i]).
- Capture is independent of IRQ_EN; IRQ_EN only masks irq_o.
- Simultaneous W1C and new edge on the same bit in the same cycle: the set wins.

Arming counter:
- A counter holds edge capture off for SYNC_STAGES+1 cycles after reset, so pins already high at reset produce no spurious rise.
- Once armed, it stays armed until the next reset.

Reset values:
- gpio_out 0, ENA 0 (so gpio_oeb all ones), PU 0, PD 0.
- IRQ_EN, RISE, FALL, STAT all 0.
- Synchroniser, `prev` and arming counter 0.
- wb_ack_o 0, wb_dat_o 0, irq_o 0.

## Timing
Bus handshake:
- Request: wb_cyc_i & wb_stb_i & ~wb_ack_o.
- Ack: wb_ack_o asserts exactly one cycle after the request is seen and stays high one cycle.
- Back-to-back: a held strobe gets ack every second cycle.
- Read data: wb_dat_o is valid in the ack cycle and holds until the next read.

Write effects: register updates are visible on the pins in the cycle after the ack edge.

Input latency:
- A gpio_in change appears in DATA reads SYNC_STAGES cycles later.
- STAT sets SYNC_STAGES+1 cycles after the change.
- irq_o is combinational from STAT and IRQ_EN, so it rises in the same cycle STAT sets.

Reset mid-transaction:
- ack is 0 in the cycle after reset; the transaction is dropped.
- The master must re-issue it.

Inputs narrower than bus glitches: pulses shorter than one clock may be missed; this is acceptable.

## Structure
Package gpio_irq_pkg holds:
- the address offset constants;
- MAX_WIDTH = 32.

Sub-module gpio_sync_edge (WIDTH, SYNC_STAGES), instanced once:
- contains the synchroniser, `prev`, arming counter and rise/fall outputs;
- reset is synchronous.

Top level: decode, registers, STAT and bus handshake.

## Test plan
- Reset, then read every register → all 0; gpio_oeb = 0xFFFFFFFF; irq_o = 0; held high gpio_in = 0xFFFFFFFF → STAT remains 0.
- Write OUT = 0x0000FFFF, then OUT_SET 0x00F00000, OUT_CLR 0x0000000F, OUT_TGL 0x000000F0 → OUT reads 0x00F0FF00. Then write OUT = 0xAABBCCDD with sel = 4'b0010 → 0x00F0CC00.
- IRQ_RISE = 0x1, IRQ_EN = 0x1; gpio_in[0] 0→1 at cycle t → STAT = 0x1 and irq_o = 1 at t+3; W1C 0x1 → irq_o = 0 one cycle after ack.
- IRQ_FALL = 0x2 with IRQ_EN = 0: falling edge on pin 1 → STAT = 0x2 and irq_o = 0. Then set IRQ_EN = 0x2 → irq_o = 1.
- W1C STAT bit 0 in the same cycle a new rising edge captures on pin 0 → STAT[0] = 1 afterwards.
- WIDTH = 8 build:
  - write 0xFFFFFFFF to OUT → reads 0x000000FF;
  - access to 0x40 → acked, reads 0;
  - wb_stb_i held high for 6 cycles → exactly 3 acks.
